// File: rtl/host_command_pkg.sv
// Shared constants for the UART command initiator: cmd_type codes, opcodes,
// FSM state encodings and per-command byte/response counts.
package host_command_pkg;

  localparam int unsigned BYTE_IDX_W = 3;
  localparam int unsigned RSP_IDX_W  = 2;
  localparam int unsigned TIMEOUT_W  = 16;

  localparam logic [1:0] CMD_RF_WRITE = 2'd0;
  localparam logic [1:0] CMD_RF_READ  = 2'd1;
  localparam logic [1:0] CMD_ALU_OP   = 2'd2;
  localparam logic [1:0] CMD_ALU_NOP  = 2'd3;

  localparam logic [7:0] OPC_RF_WRITE = 8'hAA;
  localparam logic [7:0] OPC_RF_READ  = 8'hBB;
  localparam logic [7:0] OPC_ALU_OP   = 8'hCC;
  localparam logic [7:0] OPC_ALU_NOP  = 8'hDD;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SEND     = 2'd1;
  localparam logic [1:0] ST_WAIT_RSP = 2'd2;
  localparam logic [1:0] ST_DONE     = 2'd3;

  localparam logic [BYTE_IDX_W-1:0] BYTES_RF_WRITE = 3'd3;
  localparam logic [BYTE_IDX_W-1:0] BYTES_RF_READ  = 3'd2;
  localparam logic [BYTE_IDX_W-1:0] BYTES_ALU_OP   = 3'd4;
  localparam logic [BYTE_IDX_W-1:0] BYTES_ALU_NOP  = 3'd2;

  localparam logic [RSP_IDX_W-1:0] RSPS_RF_WRITE = 2'd0;
  localparam logic [RSP_IDX_W-1:0] RSPS_RF_READ  = 2'd1;
  localparam logic [RSP_IDX_W-1:0] RSPS_ALU_OP   = 2'd2;
  localparam logic [RSP_IDX_W-1:0] RSPS_ALU_NOP  = 2'd2;

endpackage

// File: rtl/host_command_serializer.sv
// Combinational byte selector: maps command fields and a byte index to the
// outgoing UART byte, plus the byte and response counts for the command type.
module host_command_serializer
  import host_command_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned ADDRESS_WIDTH      = 4,
  parameter int unsigned ALU_FUNCTION_WIDTH = 4
) (
  input  logic [1:0]                    cmd_type,
  input  logic [ADDRESS_WIDTH-1:0]      address,
  input  logic [DATA_WIDTH-1:0]         write_data,
  input  logic [DATA_WIDTH-1:0]         operand_a,
  input  logic [DATA_WIDTH-1:0]         operand_b,
  input  logic [ALU_FUNCTION_WIDTH-1:0] alu_function,
  input  logic [BYTE_IDX_W-1:0]         byte_index,
  output logic [DATA_WIDTH-1:0]         tx_byte,
  output logic [BYTE_IDX_W-1:0]         byte_count,
  output logic [RSP_IDX_W-1:0]          rsp_count
);

  logic [DATA_WIDTH-1:0] addr_byte;
  logic [DATA_WIDTH-1:0] fn_byte;

  assign addr_byte = DATA_WIDTH'(address);
  assign fn_byte   = DATA_WIDTH'(alu_function);

  always_comb begin
    tx_byte    = '0;
    byte_count = BYTES_RF_WRITE;
    rsp_count  = RSPS_RF_WRITE;
    case (cmd_type)
      CMD_RF_WRITE: begin
        byte_count = BYTES_RF_WRITE;
        rsp_count  = RSPS_RF_WRITE;
        case (byte_index)
          3'd0:    tx_byte = DATA_WIDTH'(OPC_RF_WRITE);
          3'd1:    tx_byte = addr_byte;
          3'd2:    tx_byte = write_data;
          default: tx_byte = '0;
        endcase
      end
      CMD_RF_READ: begin
        byte_count = BYTES_RF_READ;
        rsp_count  = RSPS_RF_READ;
        case (byte_index)
          3'd0:    tx_byte = DATA_WIDTH'(OPC_RF_READ);
          3'd1:    tx_byte = addr_byte;
          default: tx_byte = '0;
        endcase
      end
      CMD_ALU_OP: begin
        byte_count = BYTES_ALU_OP;
        rsp_count  = RSPS_ALU_OP;
        case (byte_index)
          3'd0:    tx_byte = DATA_WIDTH'(OPC_ALU_OP);
          3'd1:    tx_byte = operand_a;
          3'd2:    tx_byte = operand_b;
          3'd3:    tx_byte = fn_byte;
          default: tx_byte = '0;
        endcase
      end
      default: begin
        byte_count = BYTES_ALU_NOP;
        rsp_count  = RSPS_ALU_NOP;
        case (byte_index)
          3'd0:    tx_byte = DATA_WIDTH'(OPC_ALU_NOP);
          3'd1:    tx_byte = fn_byte;
          default: tx_byte = '0;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/host_command_master.sv
// Host-side UART command initiator: serializes one command to the byte
// transmitter and assembles the response word. HOST_CMD_TIMEOUT_EN adds a
// per-byte response timeout; without it WAIT_RSP waits indefinitely.
module host_command_master
  import host_command_pkg::*;
#(
  parameter int unsigned DATA_WIDTH         = 8,
  parameter int unsigned ADDRESS_WIDTH      = 4,
  parameter int unsigned ALU_FUNCTION_WIDTH = 4,
  parameter int unsigned TIMEOUT_CYCLES     = 65535
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [1:0]                    cmd_type,
  input  logic [ADDRESS_WIDTH-1:0]      cmd_address,
  input  logic [DATA_WIDTH-1:0]         cmd_write_data,
  input  logic [DATA_WIDTH-1:0]         cmd_operand_a,
  input  logic [DATA_WIDTH-1:0]         cmd_operand_b,
  input  logic [ALU_FUNCTION_WIDTH-1:0] cmd_alu_function,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  input  logic [DATA_WIDTH-1:0]         rx_data,
  input  logic                          rx_valid,
  input  logic                          rx_parity_error,
  input  logic                          rx_frame_error,
  output logic                          rsp_valid,
  output logic [2*DATA_WIDTH-1:0]       rsp_data,
  output logic                          rsp_error,
  output logic                          rsp_timeout
);

  logic [1:0]                    state, state_next;
  logic [BYTE_IDX_W-1:0]         byte_index, byte_index_next;
  logic [BYTE_IDX_W-1:0]         byte_count, byte_count_next;
  logic [RSP_IDX_W-1:0]          rsp_index, rsp_index_next;
  logic [RSP_IDX_W-1:0]          rsp_count, rsp_count_next;
  logic [1:0]                    cap_type, cap_type_next;
  logic [ADDRESS_WIDTH-1:0]      cap_address, cap_address_next;
  logic [DATA_WIDTH-1:0]         cap_write_data, cap_write_data_next;
  logic [DATA_WIDTH-1:0]         cap_operand_a, cap_operand_a_next;
  logic [DATA_WIDTH-1:0]         cap_operand_b, cap_operand_b_next;
  logic [ALU_FUNCTION_WIDTH-1:0] cap_alu_function, cap_alu_function_next;
  logic [DATA_WIDTH-1:0]         tx_data_next;
  logic                          tx_valid_next;
  logic                          cmd_ready_next;
  logic                          rsp_valid_next;
  logic [2*DATA_WIDTH-1:0]       rsp_data_next;
  logic                          rsp_error_next;
  logic                          rsp_timeout_next;
`ifdef HOST_CMD_TIMEOUT_EN
  logic [TIMEOUT_W-1:0]          wait_count, wait_count_next;
`endif

  // In IDLE the serializer sees the live request (opcode byte); afterwards
  // it sees the captured fields and looks one byte ahead of the current one.
  logic                          ser_sel_cmd;
  logic [BYTE_IDX_W-1:0]         next_index;
  logic [1:0]                    ser_type;
  logic [ADDRESS_WIDTH-1:0]      ser_address;
  logic [DATA_WIDTH-1:0]         ser_write_data;
  logic [DATA_WIDTH-1:0]         ser_operand_a;
  logic [DATA_WIDTH-1:0]         ser_operand_b;
  logic [ALU_FUNCTION_WIDTH-1:0] ser_alu_function;
  logic [BYTE_IDX_W-1:0]         ser_index;
  logic [DATA_WIDTH-1:0]         ser_byte;
  logic [BYTE_IDX_W-1:0]         ser_byte_count;
  logic [RSP_IDX_W-1:0]          ser_rsp_count;

  assign ser_sel_cmd      = (state == ST_IDLE);
  assign next_index       = BYTE_IDX_W'(byte_index + BYTE_IDX_W'(1));
  assign ser_type         = ser_sel_cmd ? cmd_type         : cap_type;
  assign ser_address      = ser_sel_cmd ? cmd_address      : cap_address;
  assign ser_write_data   = ser_sel_cmd ? cmd_write_data   : cap_write_data;
  assign ser_operand_a    = ser_sel_cmd ? cmd_operand_a    : cap_operand_a;
  assign ser_operand_b    = ser_sel_cmd ? cmd_operand_b    : cap_operand_b;
  assign ser_alu_function = ser_sel_cmd ? cmd_alu_function : cap_alu_function;
  assign ser_index        = ser_sel_cmd ? '0 : next_index;

  host_command_serializer #(
    .DATA_WIDTH        (DATA_WIDTH),
    .ADDRESS_WIDTH     (ADDRESS_WIDTH),
    .ALU_FUNCTION_WIDTH(ALU_FUNCTION_WIDTH)
  ) u_serializer (
    .cmd_type    (ser_type),
    .address     (ser_address),
    .write_data  (ser_write_data),
    .operand_a   (ser_operand_a),
    .operand_b   (ser_operand_b),
    .alu_function(ser_alu_function),
    .byte_index  (ser_index),
    .tx_byte     (ser_byte),
    .byte_count  (ser_byte_count),
    .rsp_count   (ser_rsp_count)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_next            = state;
    byte_index_next       = byte_index;
    byte_count_next       = byte_count;
    rsp_index_next        = rsp_index;
    rsp_count_next        = rsp_count;
    cap_type_next         = cap_type;
    cap_address_next      = cap_address;
    cap_write_data_next   = cap_write_data;
    cap_operand_a_next    = cap_operand_a;
    cap_operand_b_next    = cap_operand_b;
    cap_alu_function_next = cap_alu_function;
    tx_data_next          = tx_data;
    tx_valid_next         = tx_valid;
    rsp_valid_next        = 1'b0;
    rsp_data_next         = rsp_data;
    rsp_error_next        = rsp_error;
    rsp_timeout_next      = rsp_timeout;
`ifdef HOST_CMD_TIMEOUT_EN
    wait_count_next       = wait_count;
`endif

    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          cap_type_next         = cmd_type;
          cap_address_next      = cmd_address;
          cap_write_data_next   = cmd_write_data;
          cap_operand_a_next    = cmd_operand_a;
          cap_operand_b_next    = cmd_operand_b;
          cap_alu_function_next = cmd_alu_function;
          byte_count_next       = ser_byte_count;
          rsp_count_next        = ser_rsp_count;
          byte_index_next       = '0;
          rsp_index_next        = '0;
          rsp_data_next         = '0;
          rsp_error_next        = 1'b0;
          rsp_timeout_next      = 1'b0;
          tx_data_next          = ser_byte;
          tx_valid_next         = 1'b1;
          state_next            = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_valid && tx_ready) begin
          if (next_index == byte_count) begin
            tx_valid_next = 1'b0;
            if (rsp_count != '0) begin
              state_next = ST_WAIT_RSP;
`ifdef HOST_CMD_TIMEOUT_EN
              wait_count_next = '0;
`endif
            end else begin
              state_next     = ST_DONE;
              rsp_valid_next = 1'b1;
            end
          end else begin
            byte_index_next = next_index;
            tx_data_next    = ser_byte;
          end
        end
      end
      ST_WAIT_RSP: begin
        if (rx_valid) begin
          if (rsp_index[0]) begin
            rsp_data_next[2*DATA_WIDTH-1:DATA_WIDTH] = rx_data;
          end else begin
            rsp_data_next[DATA_WIDTH-1:0] = rx_data;
          end
          rsp_error_next = rsp_error | rx_parity_error | rx_frame_error;
          rsp_index_next = RSP_IDX_W'(rsp_index + RSP_IDX_W'(1));
`ifdef HOST_CMD_TIMEOUT_EN
          wait_count_next = '0;
`endif
          if (RSP_IDX_W'(rsp_index + RSP_IDX_W'(1)) == rsp_count) begin
            state_next     = ST_DONE;
            rsp_valid_next = 1'b1;
          end
        end
`ifdef HOST_CMD_TIMEOUT_EN
        else if (wait_count == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
          state_next       = ST_DONE;
          rsp_valid_next   = 1'b1;
          rsp_timeout_next = 1'b1;
        end else begin
          wait_count_next = TIMEOUT_W'(wait_count + TIMEOUT_W'(1));
        end
`endif
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    cmd_ready_next = (state_next == ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state            <= ST_IDLE;
      byte_index       <= '0;
      byte_count       <= '0;
      rsp_index        <= '0;
      rsp_count        <= '0;
      cap_type         <= '0;
      cap_address      <= '0;
      cap_write_data   <= '0;
      cap_operand_a    <= '0;
      cap_operand_b    <= '0;
      cap_alu_function <= '0;
      tx_data          <= '0;
      tx_valid         <= 1'b0;
      cmd_ready        <= 1'b1;
      rsp_valid        <= 1'b0;
      rsp_data         <= '0;
      rsp_error        <= 1'b0;
      rsp_timeout      <= 1'b0;
`ifdef HOST_CMD_TIMEOUT_EN
      wait_count       <= '0;
`endif
    end else begin
      state            <= state_next;
      byte_index       <= byte_index_next;
      byte_count       <= byte_count_next;
      rsp_index        <= rsp_index_next;
      rsp_count        <= rsp_count_next;
      cap_type         <= cap_type_next;
      cap_address      <= cap_address_next;
      cap_write_data   <= cap_write_data_next;
      cap_operand_a    <= cap_operand_a_next;
      cap_operand_b    <= cap_operand_b_next;
      cap_alu_function <= cap_alu_function_next;
      tx_data          <= tx_data_next;
      tx_valid         <= tx_valid_next;
      cmd_ready        <= cmd_ready_next;
      rsp_valid        <= rsp_valid_next;
      rsp_data         <= rsp_data_next;
      rsp_error        <= rsp_error_next;
      rsp_timeout      <= rsp_timeout_next;
`ifdef HOST_CMD_TIMEOUT_EN
      wait_count       <= wait_count_next;
`endif
    end
  end

endmodule

// File: tb/tb_host_command_master.sv
// Directed bench for host_command_master: table of commands with hand-computed
// byte sequences and responses, plus reset-abort and timeout sequences.
module tb_host_command_master;

  localparam int unsigned TMO = 100;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_type;
  logic [3:0] cmd_address;
  logic [7:0] cmd_write_data;
  logic [7:0] cmd_operand_a;
  logic [7:0] cmd_operand_b;
  logic [3:0] cmd_alu_function;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_parity_error;
  logic       rx_frame_error;
  logic       rsp_valid;
  logic [15:0] rsp_data;
  logic       rsp_error;
  logic       rsp_timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  host_command_master #(
    .DATA_WIDTH        (8),
    .ADDRESS_WIDTH     (4),
    .ALU_FUNCTION_WIDTH(4),
    .TIMEOUT_CYCLES    (TMO)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_type        (cmd_type),
    .cmd_address     (cmd_address),
    .cmd_write_data  (cmd_write_data),
    .cmd_operand_a   (cmd_operand_a),
    .cmd_operand_b   (cmd_operand_b),
    .cmd_alu_function(cmd_alu_function),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_parity_error (rx_parity_error),
    .rx_frame_error  (rx_frame_error),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_error       (rsp_error),
    .rsp_timeout     (rsp_timeout)
  );

  // tx_bytes: byte i at [8i+:8]; rx_bytes: byte j at [8j+:8];
  // rx_errs: {frame,parity} of byte j at [2j+:2].
  typedef struct packed {
    logic [1:0]  typ;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic [7:0]  opa;
    logic [7:0]  opb;
    logic [3:0]  fn;
    logic        slow_ready;
    logic [2:0]  nbytes;
    logic [31:0] tx_bytes;
    logic [1:0]  nrx;
    logic [15:0] rx_bytes;
    logic [3:0]  rx_errs;
    logic        spurious;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_type = 2'd0; cmd_address = 4'd0; cmd_write_data = 8'd0;
    cmd_operand_a = 8'd0; cmd_operand_b = 8'd0; cmd_alu_function = 4'd0;
    tx_ready = 1'b0; rx_data = 8'd0; rx_valid = 1'b0;
    rx_parity_error = 1'b0; rx_frame_error = 1'b0;
  endtask

  task automatic issue(input vec_t v);
    cmd_valid = 1'b1; cmd_type = v.typ; cmd_address = v.addr; cmd_write_data = v.wdata;
    cmd_operand_a = v.opa; cmd_operand_b = v.opb; cmd_alu_function = v.fn;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int stalls;
    check($sformatf("v%0d_cmd_ready", idx), 32'(cmd_ready), 32'd1);
    issue(v);
    for (int i = 0; i < int'(v.nbytes); i++) begin
      stalls = v.slow_ready ? 2 : 0;
      for (int s = 0; s <= stalls; s++) begin
        check($sformatf("v%0d_tx%0d_valid", idx, i), 32'(tx_valid), 32'd1);
        check($sformatf("v%0d_tx%0d_data", idx, i), 32'(tx_data), 32'(v.tx_bytes[8*i +: 8]));
        tx_ready = (s == stalls);
        if (v.spurious && (i == int'(v.nbytes) - 1) && (s == stalls)) begin
          rx_valid = 1'b1; rx_data = 8'hFF; rx_parity_error = 1'b1;
        end
        @(negedge clk);
        tx_ready = 1'b0; rx_valid = 1'b0; rx_parity_error = 1'b0;
      end
    end
    check($sformatf("v%0d_tx_idle", idx), 32'(tx_valid), 32'd0);
    if (v.nrx != 2'd0) begin
      check($sformatf("v%0d_early_rsp", idx), 32'(rsp_valid), 32'd0);
      @(negedge clk);
      for (int j = 0; j < int'(v.nrx); j++) begin
        rx_valid = 1'b1; rx_data = v.rx_bytes[8*j +: 8];
        rx_parity_error = v.rx_errs[2*j]; rx_frame_error = v.rx_errs[2*j+1];
        @(negedge clk);
        rx_valid = 1'b0; rx_parity_error = 1'b0; rx_frame_error = 1'b0;
        if (j < int'(v.nrx) - 1)
          check($sformatf("v%0d_mid_rsp", idx), 32'(rsp_valid), 32'd0);
      end
    end
    check($sformatf("v%0d_rsp_valid", idx), 32'(rsp_valid), 32'd1);
    check($sformatf("v%0d_rsp_data", idx), 32'(rsp_data), 32'(v.exp_data));
    check($sformatf("v%0d_rsp_error", idx), 32'(rsp_error), 32'(v.exp_err));
    check($sformatf("v%0d_rsp_timeout", idx), 32'(rsp_timeout), 32'd0);
    check($sformatf("v%0d_busy", idx), 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check($sformatf("v%0d_rsp_pulse", idx), 32'(rsp_valid), 32'd0);
    check($sformatf("v%0d_ready_again", idx), 32'(cmd_ready), 32'd1);
    check($sformatf("v%0d_rsp_hold", idx), 32'(rsp_data), 32'(v.exp_data));
  endtask

  function automatic vec_t mk(input logic [1:0] typ, input logic [3:0] addr,
                              input logic [7:0] wdata, input logic [7:0] opa,
                              input logic [7:0] opb, input logic [3:0] fn,
                              input logic slow, input logic [2:0] nb,
                              input logic [31:0] txb, input logic [1:0] nrx,
                              input logic [15:0] rxb, input logic [3:0] rxe,
                              input logic spur, input logic [15:0] ed, input logic ee);
    vec_t v;
    v.typ = typ; v.addr = addr; v.wdata = wdata; v.opa = opa; v.opb = opb; v.fn = fn;
    v.slow_ready = slow; v.nbytes = nb; v.tx_bytes = txb; v.nrx = nrx;
    v.rx_bytes = rxb; v.rx_errs = rxe; v.spurious = spur; v.exp_data = ed; v.exp_err = ee;
    return v;
  endfunction

  initial begin
    int seen;
    //             typ   addr  wdata  opa    opb    fn    slow nb    tx bytes       nrx  rx bytes   errs  spur exp      err
    vecs[0] = mk(2'd0, 4'h5, 8'h3C, 8'h00, 8'h00, 4'h0, 1'b0, 3'd3, 32'h003C05AA, 2'd0, 16'h0000, 4'h0, 1'b0, 16'h0000, 1'b0);
    vecs[1] = mk(2'd1, 4'h5, 8'h00, 8'h00, 8'h00, 4'h0, 1'b1, 3'd2, 32'h000005BB, 2'd1, 16'h003C, 4'h0, 1'b0, 16'h003C, 1'b0);
    vecs[2] = mk(2'd2, 4'h0, 8'h00, 8'h0A, 8'h14, 4'h0, 1'b0, 3'd4, 32'h00140ACC, 2'd2, 16'h001E, 4'h0, 1'b0, 16'h001E, 1'b0);
    vecs[3] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'h2, 1'b0, 3'd2, 32'h000002DD, 2'd2, 16'h00C8, 4'h1, 1'b0, 16'h00C8, 1'b1);
    vecs[4] = mk(2'd1, 4'hF, 8'h00, 8'h00, 8'h00, 4'h0, 1'b0, 3'd2, 32'h00000FBB, 2'd1, 16'h00A5, 4'h0, 1'b1, 16'h00A5, 1'b0);
    vecs[5] = mk(2'd2, 4'h0, 8'h00, 8'hFF, 8'h01, 4'hF, 1'b1, 3'd4, 32'h0F01FFCC, 2'd2, 16'h1234, 4'h2, 1'b0, 16'h1234, 1'b1);
    vecs[6] = mk(2'd3, 4'h0, 8'h00, 8'h00, 8'h00, 4'hF, 1'b0, 3'd2, 32'h00000FDD, 2'd2, 16'h6655, 4'h0, 1'b0, 16'h6655, 1'b0);
    vecs[7] = mk(2'd0, 4'h0, 8'hFF, 8'h00, 8'h00, 4'h0, 1'b1, 3'd3, 32'h00FF00AA, 2'd0, 16'h0000, 4'h0, 1'b0, 16'h0000, 1'b0);

    idle_inputs();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_rsp", {13'd0, rsp_valid, rsp_error, rsp_timeout, rsp_data}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Unsolicited errored byte while idle must not leak into the next response.
    rx_valid = 1'b1; rx_data = 8'h99; rx_parity_error = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_parity_error = 1'b0;
    check("idle_rx_rsp_valid", 32'(rsp_valid), 32'd0);
    check("idle_rx_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int k = 0; k < 8; k++) run_vec(vecs[k], k);

    // Reset while the third CC byte is stalled.
    issue(vecs[2]);
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    tx_ready = 1'b0;
    check("abort_tx_data", 32'(tx_data), 32'h14);
    check("abort_tx_valid", 32'(tx_valid), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("abort_tx_drop", 32'(tx_valid), 32'd0);
    check("abort_cmd_ready", 32'(cmd_ready), 32'd1);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (rsp_valid || tx_valid || !cmd_ready) seen++;
    end
    check("abort_quiet", 32'(seen), 32'd0);
    run_vec(vecs[1], 8);

    // BB with no response byte.
    issue(vecs[1]);
    tx_ready = 1'b1;
    repeat (2) @(negedge clk);
    tx_ready = 1'b0;
`ifdef HOST_CMD_TIMEOUT_EN
    seen = -1;
    for (int c = 0; c < 2 * int'(TMO) && seen < 0; c++) begin
      if (rsp_valid) seen = c;
      else @(negedge clk);
    end
    check("tmo_latency", 32'(seen), 32'(TMO));
    check("tmo_flag", 32'(rsp_timeout), 32'd1);
    check("tmo_data", 32'(rsp_data), 32'd0);
    check("tmo_error", 32'(rsp_error), 32'd0);
    @(negedge clk);
    check("tmo_ready", 32'(cmd_ready), 32'd1);
`else
    seen = 0;
    repeat (1000) begin
      @(negedge clk);
      if (rsp_valid) seen++;
    end
    check("no_tmo_rsp_valid", 32'(seen), 32'd0);
    check("no_tmo_flag", 32'(rsp_timeout), 32'd0);
    check("no_tmo_busy", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
`endif
    run_vec(vecs[6], 9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/host_command_master.md
Name: host_command_master

Overview:
- Synthesizable host-side initiator for the system's UART command protocol.
- Accepts one command request at a time and serializes the opcode and its argument bytes to a byte-level UART transmitter.
- Collects the response bytes from a byte-level UART receiver.
- Returns read data or the ALU result as one response word, so on-chip/FPGA test harnesses can drive system_top without a behavioural bench.

Parameters:
- DATA_WIDTH, 8, width of one UART payload byte.
- ADDRESS_WIDTH, 4, register-file address width; zero-extended into one byte.
- ALU_FUNCTION_WIDTH, 4, ALU function code width; zero-extended into one byte.
- TIMEOUT_CYCLES, 65535, clk cycles to wait for each response byte (only with HOST_CMD_TIMEOUT_EN).

Ports:
- clk  in  1  block clock.
- reset  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command request valid.
- cmd_ready  out  1  high only in IDLE.
- cmd_type  in  2  0=RF write (0xAA), 1=RF read (0xBB), 2=ALU with operands (0xCC), 3=ALU without operands (0xDD).
- cmd_address  in  ADDRESS_WIDTH  register address.
- cmd_write_data  in  DATA_WIDTH  RF write data.
- cmd_operand_a  in  DATA_WIDTH  ALU operand A.
- cmd_operand_b  in  DATA_WIDTH  ALU operand B.
- cmd_alu_function  in  ALU_FUNCTION_WIDTH  ALU function.
- tx_data  out  DATA_WIDTH  byte to transmitter.
- tx_valid  out  1  byte valid.
- tx_ready  in  1  transmitter accepts byte.
- rx_data  in  DATA_WIDTH  received byte.
- rx_valid  in  1  one-cycle pulse per received byte.
- rx_parity_error  in  1  qualifies rx_valid.
- rx_frame_error  in  1  qualifies rx_valid.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  2*DATA_WIDTH  response; RF read in low byte; ALU result {second byte, first byte}.
- rsp_error  out  1  any response byte had a parity or frame error.
- rsp_timeout  out  1  response byte missing (feature only; else tied 0).

Behaviour:
- Reset values:
  - State IDLE.
  - cmd_ready=1.
  - tx_valid=0, tx_data=0.
  - rsp_valid=0, rsp_data=0, rsp_error=0, rsp_timeout=0.
  - Byte and response counters 0.
- Command capture:
  - In IDLE, cmd_valid&cmd_ready registers all cmd_* fields.
  - Captures byte_count (AA:3, BB:2, CC:4, DD:2) and rsp_count (AA:0, BB:1, CC:2, DD:2).
  - Clears rsp_data/rsp_error/rsp_timeout, then goes to SEND.
- Byte sequences:
  - AA: AA, {0,addr}, wdata.
  - BB: BB, {0,addr}.
  - CC: CC, opA, opB, {0,fn}.
  - DD: DD, {0,fn}.
- SEND:
  - tx_valid held high with the current byte until tx_valid&tx_ready; tx_data stable while waiting.
  - Next byte is presented the cycle after acceptance (no bubble required beyond that).
  - After the last byte: go to WAIT_RSP if rsp_count>0, else DONE.
- WAIT_RSP:
  - Each rx_valid stores rx_data into byte slot rsp_index (0 then 1) and ORs rx_parity_error|rx_frame_error into rsp_error.
  - An errored byte still counts as one received byte.
  - When rsp_index reaches rsp_count, go to DONE.
- Unsolicited input:
  - rx_valid in IDLE/SEND/DONE is ignored.
  - rx_valid in the same cycle as the last tx acceptance is ignored.
- DONE: rsp_valid=1 for exactly one cycle; rsp_data/rsp_error hold until the next command is accepted; then IDLE.
- Latency:
  - cmd accept to first tx_valid: 1 cycle.
  - Last rx_valid to rsp_valid: 1 cycle.
- Reset asserted mid-command: immediate return to IDLE, tx_valid drops asynchronously, no rsp_valid.
- cmd_type is 2 bits, so no illegal type exists.

Optional Feature:
- HOST_CMD_TIMEOUT_EN defined:
  - In WAIT_RSP a 16-bit counter counts cycles since entry or since the last rx_valid.
  - When it reaches TIMEOUT_CYCLES, go to DONE with rsp_timeout=1. Bytes not received read as 0.
  - The counter reloads on every rx_valid.
- Undefined: no counter; WAIT_RSP waits indefinitely; rsp_timeout tied 0.

Decomposition:
- Package host_command_pkg:
  - Opcode constants (0xAA, 0xBB, 0xCC, 0xDD).
  - cmd_type encodings.
  - State encodings IDLE/SEND/WAIT_RSP/DONE.
  - Byte/response count constants.
- Sub-module host_command_serializer:
  - Maps captured fields plus byte index to tx_data, and produces byte_count/rsp_count. Combinational mux only.
  - FSM, counters and timeout stay in the top.

Test Plan:
- RF write addr=5 data=0x3C, tx_ready always 1 -> tx bytes AA,05,3C on consecutive accepts; rsp_valid 1 cycle after third accept; rsp_data=0, rsp_error=0.
- RF read addr=5, tx_ready toggling 1-of-3 cycles, then rx 0x3C -> tx AA-free sequence BB,05 with tx_data stable while stalled; rsp_data=0x003C 1 cycle after rx_valid.
- ALU with operands A=0x0A B=0x14 fn=0 (add), rx 0x1E then 0x00 -> tx CC,0A,14,00; rsp_data=0x001E, rsp_error=0.
- ALU without operands fn=2, rx 0xC8 (parity_error=1) then 0x00 -> tx DD,02; rsp_data=0x00C8, rsp_error=1.
- Reset pulsed low while third byte of CC is stalled -> tx_valid=0 immediately, cmd_ready=1 after release, no rsp_valid; the next BB command completes normally.
- With HOST_CMD_TIMEOUT_EN and TIMEOUT_CYCLES=100: BB with no rx -> rsp_valid at 100 cycles after WAIT_RSP entry, rsp_timeout=1, rsp_data=0. Without the macro, rsp_valid never asserts within 1000 cycles.
